// File: rtl/str_next_blitter.sv
`default_nettype none
// ============================================================================
// Module   : str_next_blitter
// Purpose  : Two-stage pixel pipeline drawing the blinking "NEXT" label from
//            a combinational glyph ROM.
// Revision : 1.0 - initial release
// ============================================================================
module str_next_blitter #(
    parameter int width_p        = 32,
    parameter int glyph_h_p      = 64,
    parameter int chars_p        = 4,
    parameter int coord_w_p      = 10,
    parameter int origin_x_p     = 100,
    parameter int origin_y_p     = 50,
    parameter int blink_frames_p = 30
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    v_i,
    input  logic [coord_w_p-1:0]                    x_i,
    input  logic [coord_w_p-1:0]                    y_i,
    input  logic                                    frame_i,
    input  logic                                    enable_i,
    input  logic                                    blink_i,
    output logic                                    ready_o,
    output logic [$clog2(chars_p*glyph_h_p)-1:0]    rom_addr_o,
    input  logic [width_p-1:0]                      rom_data_i,
    output logic                                    v_o,
    output logic                                    pixel_o,
    output logic                                    in_region_o,
    input  logic                                    yumi_i
);

    localparam int c_LXW    = coord_w_p + 1;
    localparam int c_ADDR_W = $clog2(chars_p * glyph_h_p);
    localparam int c_COL_W  = (width_p > 1) ? $clog2(width_p) : 1;
    localparam int c_FC_W   = (blink_frames_p > 0) ? $clog2(blink_frames_p + 1) : 1;

    typedef enum logic [0:0] {
        ST_VISIBLE = 1'b0,
        ST_HIDDEN  = 1'b1
    } blink_state_t;

    // One extra sign bit keeps coordinates left of / above the origin negative.
    logic signed [c_LXW-1:0] w_lx;
    logic signed [c_LXW-1:0] w_ly;
    int                      w_lx_int;
    int                      w_ly_int;
    logic                    w_in_region;
    logic [c_ADDR_W-1:0]     w_addr;
    logic [c_COL_W-1:0]      w_col;
    logic [width_p-1:0]      w_rom_rev;
    logic                    w_rom_bit;
    logic                    w_adv;
    logic                    w_visible;

    blink_state_t            r_state;
    logic [c_FC_W-1:0]       r_fc;

    logic                    r_s1_v;
    logic [c_ADDR_W-1:0]     r_s1_addr;
    logic [c_COL_W-1:0]      r_s1_col;
    logic                    r_s1_inreg;
    logic                    r_s1_show;
    logic                    r_v_o;
    logic                    r_pixel_o;
    logic                    r_in_region_o;

    assign w_lx = $signed({1'b0, x_i}) - $signed(c_LXW'(origin_x_p));
    assign w_ly = $signed({1'b0, y_i}) - $signed(c_LXW'(origin_y_p));

    always_comb begin
        w_lx_int    = int'(w_lx);
        w_ly_int    = int'(w_ly);
        w_in_region = !w_lx[c_LXW-1] && !w_ly[c_LXW-1] &&
                      (w_lx_int < chars_p * width_p) && (w_ly_int < glyph_h_p);
        w_col       = c_COL_W'(w_lx_int % width_p);
        w_addr      = '0;
        if (w_in_region) begin
            w_addr = c_ADDR_W'((w_lx_int / width_p) * glyph_h_p + w_ly_int);
        end
    end

    // Column 0 is the MSB of the ROM word; reverse once so col indexes directly.
    always_comb begin
        w_rom_rev = '0;
        for (int i = 0; i < width_p; i++) begin
            w_rom_rev[i] = rom_data_i[width_p-1-i];
        end
        w_rom_bit = w_rom_rev[r_s1_col];
    end

    assign w_adv     = ~r_v_o | yumi_i;
    assign w_visible = (r_state == ST_VISIBLE);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_VISIBLE;
            r_fc    <= '0;
        end else if (frame_i) begin
            if (!blink_i || (blink_frames_p == 0)) begin
                r_state <= ST_VISIBLE;
                r_fc    <= '0;
            end else if (r_fc == c_FC_W'(blink_frames_p - 1)) begin
                r_fc    <= '0;
                r_state <= (r_state == ST_VISIBLE) ? ST_HIDDEN : ST_VISIBLE;
            end else begin
                r_fc    <= r_fc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_s1_v        <= 1'b0;
            r_s1_addr     <= '0;
            r_s1_col      <= '0;
            r_s1_inreg    <= 1'b0;
            r_s1_show     <= 1'b0;
            r_v_o         <= 1'b0;
            r_pixel_o     <= 1'b0;
            r_in_region_o <= 1'b0;
        end else if (w_adv) begin
            r_s1_v        <= v_i;
            r_s1_addr     <= w_addr;
            r_s1_col      <= w_col;
            r_s1_inreg    <= w_in_region;
            r_s1_show     <= w_visible & enable_i;
            r_v_o         <= r_s1_v;
            r_in_region_o <= r_s1_inreg;
            r_pixel_o     <= r_s1_inreg & w_rom_bit & r_s1_show;
        end
    end

    assign ready_o     = w_adv;
    assign rom_addr_o  = r_s1_addr;
    assign v_o         = r_v_o;
    assign pixel_o     = r_pixel_o;
    assign in_region_o = r_in_region_o;

endmodule
`default_nettype wire

// File: tb/tb_str_next_blitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_str_next_blitter
// Purpose  : Randomized and directed bench with a queue-based pixel model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_str_next_blitter;

    localparam int c_BF = 2;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic [9:0]  x_i;
    logic [9:0]  y_i;
    logic        frame_i;
    logic        enable_i;
    logic        blink_i;
    logic        ready_o;
    logic [7:0]  rom_addr_o;
    logic [31:0] rom_data_i;
    logic        v_o;
    logic        pixel_o;
    logic        in_region_o;
    logic        yumi_i;

    logic [31:0] rom [0:255];
    assign rom_data_i = rom[rom_addr_o];

    always #5 clk = ~clk;

    str_next_blitter #(
        .width_p(32), .glyph_h_p(64), .chars_p(4), .coord_w_p(10),
        .origin_x_p(100), .origin_y_p(50), .blink_frames_p(c_BF)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .x_i(x_i), .y_i(y_i),
        .frame_i(frame_i), .enable_i(enable_i), .blink_i(blink_i),
        .ready_o(ready_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .v_o(v_o), .pixel_o(pixel_o), .in_region_o(in_region_o), .yumi_i(yumi_i)
    );

    typedef struct packed {
        logic pix;
        logic inr;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt;
    int   n_checks;
    int   n_pass;
    int   yumi_mode;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: label box 128x64 at (100,50), 32-wide glyphs, MSB = leftmost.
    function automatic exp_t model(input int x, input int y, input logic en, input logic vis);
        exp_t        e;
        int          lx;
        logic [31:0] word;
        e.inr = (x >= 100) && (x < 228) && (y >= 50) && (y < 114);
        e.pix = 1'b0;
        if (e.inr) begin
            lx    = x - 100;
            word  = rom[(lx / 32) * 64 + (y - 50)];
            e.pix = word[31 - (lx % 32)] & en & vis;
        end
        return e;
    endfunction

    function automatic logic m_visible();
        return (c_BF == 0) || (((m_cnt / c_BF) % 2) == 0);
    endfunction

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (reset_i) begin
                exp_q.delete();
                m_cnt = 0;
            end else begin
                if (v_o) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_spurious_v_o", 32'(v_o), 32'd0);
                    end else begin
                        chk("sb_pixel", 32'(pixel_o), 32'(exp_q[0].pix));
                        chk("sb_in_region", 32'(in_region_o), 32'(exp_q[0].inr));
                        if (yumi_i) void'(exp_q.pop_front());
                    end
                end
                if (v_i && ready_o)
                    exp_q.push_back(model(int'(x_i), int'(y_i), enable_i, m_visible()));
                if (frame_i) m_cnt = blink_i ? m_cnt + 1 : 0;
            end
        end
    endtask

    task automatic yumi_loop();
        forever begin
            @(posedge clk);
            #2;
            case (yumi_mode)
                0:       yumi_i = 1'b1;
                1:       yumi_i = 1'($urandom_range(0, 1));
                default: yumi_i = 1'b0;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y);
        logic got;
        got = 1'b0;
        v_i = 1'b1;
        x_i = 10'(x);
        y_i = 10'(y);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            got = ready_o;
            step();
            if (got) break;
        end
        v_i = 1'b0;
        chk("send_accept", 32'(got), 32'd1);
    endtask

    task automatic probe(input int x, input int y, output logic pix, output logic inr,
                         output logic [7:0] addr, output int lat);
        send(x, y);
        pix  = 1'b0;
        inr  = 1'b0;
        addr = '0;
        lat  = 0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (t == 1) addr = rom_addr_o;
            if (v_o) begin
                lat = t;
                pix = pixel_o;
                inr = in_region_o;
                break;
            end
            step();
        end
        step();
        if (lat == 0) chk("probe_timeout", 32'(lat), 32'd2);
    endtask

    task automatic pulse();
        frame_i = 1'b1;
        step();
        frame_i = 1'b0;
    endtask

    task automatic drain(input string name);
        v_i       = 1'b0;
        frame_i   = 1'b0;
        yumi_mode = 0;
        repeat (6) step();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic       pix;
        logic       inr;
        logic [7:0] addr;
        int         lat;
        logic       exp_blink [5];

        n_checks = 0; n_pass = 0; m_cnt = 0; yumi_mode = 0;
        reset_i = 1'b1; v_i = 1'b0; x_i = '0; y_i = '0; frame_i = 1'b0;
        enable_i = 1'b1; blink_i = 1'b1; yumi_i = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[11] = 32'h7FC0_03FF;
        rom[89] = (rom[89] & ~(32'h1 << 19)) | (32'h1 << 18);

        fork
            monitor_loop();
            yumi_loop();
        join_none

        repeat (2) step();
        reset_i = 1'b0;
        @(negedge clk);
        chk("reset_v_o", 32'(v_o), 32'd0);
        chk("reset_pixel_o", 32'(pixel_o), 32'd0);
        chk("reset_in_region_o", 32'(in_region_o), 32'd0);
        chk("reset_rom_addr_o", 32'(rom_addr_o), 32'd0);
        chk("reset_ready_o", 32'(ready_o), 32'd1);
        step();

        // Row 11 of glyph 0: 0x7FC003FF scanned MSB first.
        for (int x = 100; x < 132; x++) begin
            probe(x, 61, pix, inr, addr, lat);
            chk("row11_addr", 32'(addr), 32'd11);
            chk("row11_pixel", 32'(pix), 32'(((x >= 101) && (x <= 109)) || (x >= 122)));
        end

        probe(145, 75, pix, inr, addr, lat);
        chk("char1_addr", 32'(addr), 32'd89);
        chk("char1_pixel", 32'(pix), 32'd1);
        chk("char1_latency", 32'(lat), 32'd2);
        probe(144, 75, pix, inr, addr, lat);
        chk("char1_dark_pixel", 32'(pix), 32'd0);

        probe(99, 60, pix, inr, addr, lat);
        chk("edge_x99_inr", 32'(inr), 32'd0);
        chk("edge_x99_pix", 32'(pix), 32'd0);
        probe(228, 60, pix, inr, addr, lat);
        chk("edge_x228_inr", 32'(inr), 32'd0);
        chk("edge_x228_pix", 32'(pix), 32'd0);
        probe(150, 114, pix, inr, addr, lat);
        chk("edge_y114_inr", 32'(inr), 32'd0);
        chk("edge_y114_pix", 32'(pix), 32'd0);
        probe(100, 49, pix, inr, addr, lat);
        chk("edge_y49_inr", 32'(inr), 32'd0);
        chk("edge_y49_addr", 32'(addr), 32'd0);
        probe(227, 113, pix, inr, addr, lat);
        chk("edge_corner_inr", 32'(inr), 32'd1);
        probe(5, 700, pix, inr, addr, lat);
        chk("edge_far_inr", 32'(inr), 32'd0);

        enable_i = 1'b0;
        probe(101, 61, pix, inr, addr, lat);
        chk("disabled_pixel", 32'(pix), 32'd0);
        chk("disabled_inr", 32'(inr), 32'd1);
        enable_i = 1'b1;

        exp_blink[0] = 1'b1; exp_blink[1] = 1'b1; exp_blink[2] = 1'b0;
        exp_blink[3] = 1'b0; exp_blink[4] = 1'b1;
        blink_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            probe(101, 61, pix, inr, addr, lat);
            chk("blink_seq", 32'(pix), 32'(exp_blink[k]));
            if (k < 4) pulse();
        end
        pulse();
        pulse();
        probe(101, 61, pix, inr, addr, lat);
        chk("blink_hidden", 32'(pix), 32'd0);
        blink_i = 1'b0;
        pulse();
        probe(101, 61, pix, inr, addr, lat);
        chk("blink_drop", 32'(pix), 32'd1);

        // Enter HIDDEN, then reset with two pixels in flight.
        blink_i = 1'b1;
        pulse();
        pulse();
        send(101, 61);
        send(102, 61);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        @(negedge clk);
        chk("midreset_v_o", 32'(v_o), 32'd0);
        chk("midreset_rom_addr", 32'(rom_addr_o), 32'd0);
        chk("midreset_ready", 32'(ready_o), 32'd1);
        step();
        drain("midreset_no_stale");
        probe(101, 61, pix, inr, addr, lat);
        chk("midreset_visible", 32'(pix), 32'd1);

        fork
            begin
                for (int i = 0; i < 8; i++) send(100 + i * 7, 61 + i);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                yumi_mode = 2;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready", 32'(ready_o), 32'd0);
                    step();
                end
                yumi_mode = 0;
            end
        join
        drain("stall_drain");

        yumi_mode = 1;
        for (int c = 0; c < 600; c++) begin
            v_i      = 1'($urandom_range(0, 1));
            x_i      = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                                   : 10'($urandom_range(90, 240));
            y_i      = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                                   : 10'($urandom_range(40, 120));
            enable_i = ($urandom_range(0, 7) != 0);
            blink_i  = ($urandom_range(0, 15) != 0);
            frame_i  = ($urandom_range(0, 5) == 0);
            step();
        end
        drain("random_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/str_next_blitter.md
# str_next_blitter

Pixel-stream stage that draws the 4-character "NEXT" label beside the preview well. It sits directly upstream of the `memory_str_next` glyph ROM and downstream of the VGA scan generator. It maps each incoming screen coordinate to a ROM row address, reads the 32-bit row back, and selects the pixel bit. It emits a registered, blink-gated foreground flag to the pixel mux.

## Interface
- `width_p`, 32: glyph row width in pixels; equals the ROM word width.
- `glyph_h_p`, 64: rows per character; ROM depth is `chars_p*glyph_h_p`.
- `chars_p`, 4: characters, laid out left to right.
- `coord_w_p`, 10: screen coordinate width.
- `origin_x_p`, 100: screen x of the label's top-left pixel.
- `origin_y_p`, 50: screen y of the label's top-left pixel.
- `blink_frames_p`, 30: frames per visible/hidden half-period; 0 disables blinking.
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `v_i` in 1: input pixel valid.
- `x_i` in `coord_w_p`: screen x.
- `y_i` in `coord_w_p`: screen y.
- `frame_i` in 1: one-cycle pulse at frame start, independent of `v_i`.
- `enable_i` in 1: label shown when 1 (game-over screens drive 0).
- `blink_i` in 1: blink mode request.
- `ready_o` out 1: stage can accept a pixel.
- `rom_addr_o` out `$clog2(chars_p*glyph_h_p)`: glyph ROM row address (combinational ROM).
- `rom_data_i` in `width_p`: ROM row data.
- `v_o` out 1: output valid.
- `pixel_o` out 1: foreground pixel.
- `in_region_o` out 1: coordinate lies inside the label box.
- `yumi_i` in 1: consumer takes output this cycle.

## Operation
- **Region check**
  - `lx = x_i - origin_x_p`, `ly = y_i - origin_y_p`, computed at `coord_w_p+1` bits with sign.
  - In region iff `0 <= lx < chars_p*width_p` and `0 <= ly < glyph_h_p`.
- **Address generation**
  - `char = lx / width_p`, `col = lx % width_p`.
  - `addr = char*glyph_h_p + ly`.
  - Out of region: `addr = 0`.
- **Bit order:** column `col` (0 = leftmost) selects `rom_data_i[width_p-1-col]`.
- **Pipeline:** two stages, all advancing on `adv = ~v_o | yumi_i`; `ready_o = adv`.
  - S1 registers `v`, `addr`, `col`, `in_region`. `rom_addr_o` is driven from S1 `addr`.
  - S2 registers `v_o`, `in_region_o`, and `pixel_o = in_region & rom_bit & visible & enable_i`.
  - `enable_i` is sampled at S1.
- **Stall:** when `~adv`, S1 and S2 hold. `rom_addr_o` stays constant, so the ROM data is stable.
- **Bubbles:** S1 `v = 0` propagates as `v_o = 0`. Bubbles are collapsed only when `adv`.
- **Blink state machine**
  - States: VISIBLE and HIDDEN.
  - Frame counter `fc`, width `$clog2(blink_frames_p+1)`.
  - On `frame_i`: if `blink_i` is 0, `fc = 0` and the state returns to VISIBLE.
  - Otherwise `fc` increments. At `fc == blink_frames_p-1` it wraps to 0 and the state toggles.
  - `blink_frames_p == 0`: always VISIBLE.
  - `frame_i` is processed even during a stall. `visible` is sampled when a pixel enters S1.

## Timing
- Latency: 2 cycles from accept (`v_i & ready_o`) to `v_o`, with no stalls. Throughput: 1 pixel/cycle.
- Reset (synchronous, takes effect at the clock edge):
  - Outputs: `v_o = 0`, `pixel_o = 0`, `in_region_o = 0`, `rom_addr_o = 0`.
  - Internal: S1 `v = 0`, `fc = 0`, state VISIBLE.
  - `ready_o = 1` in the cycle after reset.
- Reset mid-stream discards both in-flight pixels; none are emitted.
- Blink toggle takes effect for pixels accepted in the cycle after the wrapping `frame_i`.
- Boundaries:
  - `lx = chars_p*width_p` (x = 228) and `ly = glyph_h_p` (y = 114) are out of region.
  - `x_i < origin_x_p` is out of region; the signed compare prevents wrap-around.

## Test plan
- **Row 11, char 0 bit order**
  - Stimulus: pixels at y = 61, x = 100..131.
  - Required: `rom_addr_o = 11` and `rom_data_i = 0x7FC003FF`.
  - `pixel_o` = 0 at x = 100, 1 at x = 101..109, 0 at x = 110..121, 1 at x = 122..131.
- **Char 1 addressing**
  - Stimulus: (x = 145, y = 75).
  - Required: `rom_addr_o = 89`, `pixel_o = 1`, `v_o` exactly 2 cycles after accept.
  - (x = 144, y = 75) gives `pixel_o = 0`.
- **Region edges**
  - Stimulus: (99, 60), (228, 60), (150, 114), (100, 49).
  - Required: `in_region_o = 0`, `pixel_o = 0`.
  - (227, 113) gives `in_region_o = 1`.
- **Backpressure**
  - Stimulus: stream of 8 pixels with `yumi_i` low for 3 cycles mid-stream.
  - Required: `ready_o = 0` during the stall, no pixel lost or duplicated, output order preserved.
- **Blink**
  - Stimulus: `blink_frames_p = 2`, `blink_i = 1`, 4 `frame_i` pulses.
  - Required: lit pixel (101, 61) is 1, 1, 0, 0, then 1 after the 4th pulse.
  - Dropping `blink_i` while HIDDEN returns to 1 on the next `frame_i`.
- **Reset**
  - Stimulus: assert `reset_i` with 2 pixels in flight.
  - Required: `v_o = 0` next cycle, no stale pixel emitted afterwards, blink state VISIBLE.
